pdm_demod: RTL



---
 rtl/pdm_demod.sv | 97 +++++++++
 1 files changed

// File: rtl/pdm_demod.sv
// PDM-to-PCM receiver: 2-flop input synchronizer, 2nd-order CIC decimator,
// then scaling and saturation to an OUT_W-bit unsigned sample.
module pdm_demod #(
    parameter int DECIM      = 32,
    parameter int OUT_W      = 10,
    parameter int SAMPLE_DIV = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             pdm_in,
    output logic [OUT_W-1:0] sample_out,
    output logic             sample_valid,
    output logic             sat
);
    localparam int LOG2D = $clog2(DECIM);
    localparam int W     = 2 * LOG2D + 1;
    localparam int SHIFT = 2 * LOG2D - OUT_W;
    localparam logic [LOG2D-1:0] DC_LAST = LOG2D'(DECIM - 1);

    logic [1:0]       sync;
    logic             x;
    logic             tick;
    logic             ds;
    logic [LOG2D-1:0] dc;
    logic [W-1:0]     i1, i2, i2_d, c1_r, c1_d, c2;
    logic [OUT_W:0]   y;
    logic [2:0]       vld_pipe;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sync <= '0;
        else         sync <= {sync[0], pdm_in};
    end
    assign x = sync[1];

    generate
        if (SAMPLE_DIV == 1) begin : g_tick_full
            assign tick = 1'b1;
        end else begin : g_tick_div
            localparam int TW = $clog2(SAMPLE_DIV);
            localparam logic [TW-1:0] TC_LAST = TW'(SAMPLE_DIV - 1);
            logic [TW-1:0] tc;
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn)           tc <= '0;
                else if (tc == TC_LAST) tc <= '0;
                else                   tc <= tc + TW'(1);
            end
            assign tick = (tc == '0);
        end
    endgenerate

    assign ds = tick && (dc == DC_LAST);

    // i2 accumulates the pre-update i1, so each bit lands one tick late; harmless fixed skew.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i1 <= '0;
            i2 <= '0;
            dc <= '0;
        end else if (tick) begin
            i1 <= i1 + W'(x);
            i2 <= i2 + i1;
            dc <= ds ? '0 : dc + LOG2D'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) vld_pipe <= '0;
        else         vld_pipe <= {vld_pipe[1:0], ds};
    end

    assign c2 = c1_r - c1_d;
    assign y  = c2[W-1:SHIFT];

    // Comb delays start at zero, so the first two samples after reset are transient.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i2_d       <= '0;
            c1_r       <= '0;
            c1_d       <= '0;
            sample_out <= '0;
            sat        <= 1'b0;
        end else begin
            if (vld_pipe[0]) begin
                c1_r <= i2 - i2_d;
                i2_d <= i2;
            end
            if (vld_pipe[1]) begin
                c1_d       <= c1_r;
                sample_out <= y[OUT_W] ? '1 : y[OUT_W-1:0];
                sat        <= y[OUT_W];
            end
        end
    end

    assign sample_valid = vld_pipe[2];

endmodule
